// File: rtl/bf16_add_sched.sv
// Two-requester BF16 adder front end with a one-deep result register.
// Round-robin grant, one op per cycle, result one cycle after accept.
module bf16_add (
    input  logic        sa,
    input  logic [7:0]  ea,
    input  logic [6:0]  ma,
    input  logic        sb,
    input  logic [7:0]  eb,
    input  logic [6:0]  mb,
    output logic [15:0] res
);
    logic        nan_a, nan_b, inf_a, inf_b;
    logic        a_big, sl, sub, lost, up;
    logic [7:0]  el, es, xl, xs, d;
    logic [6:0]  ml, ms;
    logic [4:0]  dc, lz, sft;
    logic [17:0] ws, sh;
    logic [18:0] wl, sm, sum, n;
    logic [8:0]  eb9;
    logic [15:0] rnd;

    assign nan_a = (&ea) & (|ma);
    assign nan_b = (&eb) & (|mb);
    assign inf_a = (&ea) & ~(|ma);
    assign inf_b = (&eb) & ~(|mb);

    // order by magnitude so the subtraction never goes negative
    assign a_big = {ea, ma} >= {eb, mb};
    assign el    = a_big ? ea : eb;
    assign es    = a_big ? eb : ea;
    assign ml    = a_big ? ma : mb;
    assign ms    = a_big ? mb : ma;
    assign sl    = a_big ? sa : sb;
    assign sub   = sa ^ sb;

    assign xl = (el == 8'd0) ? 8'd1 : el;
    assign xs = (es == 8'd0) ? 8'd1 : es;
    assign d  = xl - xs;
    assign dc = (d > 8'd18) ? 5'd18 : d[4:0];

    assign ws   = {es != 8'd0, ms, 10'b0};
    assign sh   = ws >> dc;
    assign lost = (sh << dc) != ws;
    assign sm   = {1'b0, sh[17:1], sh[0] | lost};
    assign wl   = {1'b0, el != 8'd0, ml, 10'b0};
    assign sum  = sub ? wl - sm : wl + sm;

    always_comb begin
        lz = 5'd19;
        for (int i = 0; i < 19; i++) begin
            if (sum[i]) lz = 5'(18 - i);
        end
    end

    // stop normalising at the minimum exponent to form subnormals
    assign sft = ({3'b0, lz} <= xl) ? lz : xl[4:0];
    assign n   = sum << sft;
    assign eb9 = n[18] ? ({1'b0, xl} + 9'd1 - {4'b0, sft}) : 9'd0;
    assign up  = n[10] & ((|n[9:0]) | n[11]);
    assign rnd = {eb9, n[17:11]} + {15'b0, up};

    always_comb begin
        res = {sl, rnd[14:0]};
        if (rnd[15:7] >= 9'd255) res = {sl, 8'hFF, 7'h00};
        if (sum == 19'd0) res = {sa & sb, 15'b0};
        if (inf_a | inf_b) res = inf_a ? {sa, ea, ma} : {sb, eb, mb};
        if (nan_a | nan_b | (inf_a & inf_b & sub)) res = 16'h7FC0;
    end
endmodule

module bf16_add_sched (
    input  logic        clk,
    input  logic        nreset,
    input  logic [1:0]  req_valid_i,
    output logic [1:0]  req_ready_o,
    input  logic [15:0] req0_a_i,
    input  logic [15:0] req0_b_i,
    input  logic [15:0] req1_a_i,
    input  logic [15:0] req1_b_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        rsp_id_o,
    output logic [15:0] rsp_res_o,
    output logic [15:0] ops_cnt_o
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t      state;
    logic        ptr, open, xfer, gid;
    logic [1:0]  gnt;
    logic [15:0] op_a, op_b, sum;

    assign open = nreset & ((state == EMPTY) | rsp_ready_i);

    always_comb begin
        gnt = 2'b00;
        if (open) begin
            if (req_valid_i[ptr]) gnt[ptr] = 1'b1;
            else if (req_valid_i[~ptr]) gnt[~ptr] = 1'b1;
        end
    end

    assign req_ready_o = gnt;
    assign xfer        = |(gnt & req_valid_i);
    assign gid         = gnt[1];
    assign op_a        = gid ? req1_a_i : req0_a_i;
    assign op_b        = gid ? req1_b_i : req0_b_i;
    assign rsp_valid_o = (state == FULL);

    bf16_add u_add (
        .sa  (op_a[15]),
        .ea  (op_a[14:7]),
        .ma  (op_a[6:0]),
        .sb  (op_b[15]),
        .eb  (op_b[14:7]),
        .mb  (op_b[6:0]),
        .res (sum)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= EMPTY;
            ptr       <= 1'b0;
            rsp_id_o  <= 1'b0;
            rsp_res_o <= 16'h0000;
            ops_cnt_o <= 16'h0000;
        end else if (xfer) begin
            state     <= FULL;
            ptr       <= ~gid;
            rsp_id_o  <= gid;
            rsp_res_o <= sum;
            ops_cnt_o <= ops_cnt_o + 16'd1;
        end else if (rsp_ready_i) begin
            state     <= EMPTY;
        end
    end
endmodule

// File: tb/tb_bf16_add_sched.sv
// Random and directed checks of bf16_add_sched against a
// real-arithmetic BF16 model and a queue-free transaction model.
module tb_bf16_add_sched;
    logic        clk = 1'b0;
    logic        nreset;
    logic [1:0]  req_valid_i;
    logic [1:0]  req_ready_o;
    logic [15:0] req0_a_i, req0_b_i, req1_a_i, req1_b_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic        rsp_id_o;
    logic [15:0] rsp_res_o;
    logic [15:0] ops_cnt_o;

    int n_chk = 0;
    int n_bad = 0;

    bit          m_full;
    bit          m_ptr;
    bit          m_id;
    logic [15:0] m_res;
    logic [15:0] m_cnt;

    always #5 clk = ~clk;

    bf16_add_sched dut (
        .clk         (clk),
        .nreset      (nreset),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req0_a_i    (req0_a_i),
        .req0_b_i    (req0_b_i),
        .req1_a_i    (req1_a_i),
        .req1_b_i    (req1_b_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_id_o    (rsp_id_o),
        .rsp_res_o   (rsp_res_o),
        .ops_cnt_o   (ops_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic real b2r(input logic [15:0] a);
        logic [10:0] e11;
        if (a[14:7] == 8'd0) return $bitstoreal({a[15], 63'b0});
        e11 = {3'b0, a[14:7]} + 11'd896;
        return $bitstoreal({a[15], e11, a[6:0], 45'b0});
    endfunction

    // round a double to bf16, nearest-even; operands keep it in normal range
    function automatic logic [15:0] r2b(input real r);
        logic [63:0] bb;
        logic [10:0] e;
        logic        rb;
        logic [14:0] v;
        bb = $realtobits(r);
        if (bb[62:52] == 11'd0) return {bb[63], 15'b0};
        e  = bb[62:52] - 11'd896;
        rb = bb[44] & ((|bb[43:0]) | bb[45]);
        v  = {e[7:0], bb[51:45]} + {14'b0, rb};
        return {bb[63], v};
    endfunction

    function automatic logic [15:0] ref_add(input logic [15:0] a,
                                            input logic [15:0] b);
        return r2b(b2r(a) + b2r(b));
    endfunction

    function automatic logic [15:0] rnd_op();
        logic [15:0] x;
        logic [7:0]  e;
        e = 8'(110 + $urandom_range(0, 35));
        x = {1'(($urandom)), e, 7'($urandom)};
        if ($urandom_range(0, 15) == 0) x = {x[15], 15'b0};
        return x;
    endfunction

    // one clock: drive at negedge, check ready, check outputs after posedge
    task automatic cyc(input logic [1:0] v, input logic [15:0] a0,
                       input logic [15:0] b0, input logic [15:0] a1,
                       input logic [15:0] b1, input logic rr,
                       output logic [1:0] rdy_seen);
        logic [1:0] g;
        bit         k;
        req_valid_i = v;
        req0_a_i = a0; req0_b_i = b0;
        req1_a_i = a1; req1_b_i = b1;
        rsp_ready_i = rr;
        #1;
        g = 2'b00;
        if (!m_full || rr) begin
            if (v[m_ptr]) g[m_ptr] = 1'b1;
            else if (v[!m_ptr]) g[!m_ptr] = 1'b1;
        end
        rdy_seen = req_ready_o;
        chk("ready", {30'b0, req_ready_o}, {30'b0, g});
        @(posedge clk);
        #1;
        if (g != 2'b00) begin
            k      = g[1];
            m_res  = k ? ref_add(a1, b1) : ref_add(a0, b0);
            m_id   = k;
            m_full = 1'b1;
            m_ptr  = !k;
            m_cnt  = m_cnt + 16'd1;
        end else if (rr) begin
            m_full = 1'b0;
        end
        chk("rsp_valid", {31'b0, rsp_valid_o}, {31'b0, m_full});
        chk("rsp_id", {31'b0, rsp_id_o}, {31'b0, m_id});
        chk("rsp_res", {16'b0, rsp_res_o}, {16'b0, m_res});
        chk("ops_cnt", {16'b0, ops_cnt_o}, {16'b0, m_cnt});
        @(negedge clk);
    endtask

    task automatic rnd_cyc(input logic [1:0] v, input logic rr,
                           output logic [1:0] rdy_seen);
        logic [15:0] a0, b0, a1, b1;
        a0 = rnd_op(); b0 = rnd_op();
        a1 = rnd_op(); b1 = rnd_op();
        if ($urandom_range(0, 7) == 0) b0 = a0 ^ 16'h8000;
        if ($urandom_range(0, 7) == 0) b1 = a1 ^ 16'h8000;
        cyc(v, a0, b0, a1, b1, rr, rdy_seen);
    endtask

    // entered and left at a negedge; release lines up with the next posedge
    task automatic hw_reset();
        nreset = 1'b0;
        req_valid_i = 2'b11;
        rsp_ready_i = 1'b1;
        #1;
        chk("rst_ready", {30'b0, req_ready_o}, 32'd0);
        chk("rst_valid", {31'b0, rsp_valid_o}, 32'd0);
        chk("rst_id", {31'b0, rsp_id_o}, 32'd0);
        chk("rst_res", {16'b0, rsp_res_o}, 32'd0);
        chk("rst_cnt", {16'b0, ops_cnt_o}, 32'd0);
        @(negedge clk);
        req_valid_i = 2'b00;
        nreset = 1'b1;
        m_full = 1'b0; m_ptr = 1'b0; m_id = 1'b0;
        m_res = 16'h0000; m_cnt = 16'h0000;
    endtask

    initial begin
        logic [1:0] rs;
        int         stalls;
        nreset = 1'b0;
        req_valid_i = 2'b00;
        rsp_ready_i = 1'b0;
        req0_a_i = '0; req0_b_i = '0;
        req1_a_i = '0; req1_b_i = '0;
        repeat (2) @(negedge clk);
        hw_reset();

        cyc(2'b01, 16'h0000, 16'h8000, 16'h0000, 16'h0000, 1'b1, rs);
        chk("zero_res", {16'b0, rsp_res_o}, 32'h0000);
        chk("zero_id", {31'b0, rsp_id_o}, 32'd0);
        chk("zero_cnt", {16'b0, ops_cnt_o}, 32'd1);

        hw_reset();
        cyc(2'b11, 16'h3F80, 16'h3F80, 16'h4000, 16'h3F80, 1'b1, rs);
        chk("arb0_rdy", {30'b0, rs}, 32'd1);
        chk("arb0_res", {16'b0, rsp_res_o}, 32'h4000);
        chk("arb0_id", {31'b0, rsp_id_o}, 32'd0);
        cyc(2'b11, 16'h3F80, 16'h3F80, 16'h4000, 16'h3F80, 1'b1, rs);
        chk("arb1_rdy", {30'b0, rs}, 32'd2);
        chk("arb1_res", {16'b0, rsp_res_o}, 32'h4040);
        chk("arb1_id", {31'b0, rsp_id_o}, 32'd1);

        cyc(2'b01, 16'h3F80, 16'h3F80, 16'h0000, 16'h0000, 1'b1, rs);
        for (int i = 0; i < 3; i++) begin
            cyc(2'b10, 16'h0000, 16'h0000, 16'h4000, 16'h3F80, 1'b0, rs);
            chk("bp_rdy", {30'b0, rs}, 32'd0);
            chk("bp_res", {16'b0, rsp_res_o}, 32'h4000);
        end
        cyc(2'b10, 16'h0000, 16'h0000, 16'h4000, 16'h3F80, 1'b1, rs);
        chk("bp_go_rdy", {30'b0, rs}, 32'd2);
        chk("bp_go_res", {16'b0, rsp_res_o}, 32'h4040);

        for (int i = 0; i < 400; i++)
            rnd_cyc(2'($urandom), 1'($urandom_range(0, 3) != 0), rs);

        cyc(2'b01, 16'h3F80, 16'h3F80, 16'h0000, 16'h0000, 1'b0, rs);
        chk("mid_full", {31'b0, rsp_valid_o}, 32'd1);
        hw_reset();
        cyc(2'b11, 16'h4000, 16'h4000, 16'h3F80, 16'h3F80, 1'b1, rs);
        chk("mid_ptr", {30'b0, rs}, 32'd1);

        hw_reset();
        stalls = 0;
        for (int i = 0; i < 65536; i++) begin
            rnd_cyc(2'b11, 1'b1, rs);
            if (rs == 2'b00) stalls++;
        end
        chk("wrap_cnt", {16'b0, ops_cnt_o}, 32'd0);
        chk("wrap_stalls", stalls, 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/bf16_add_sched.md
BF16_ADD_SCHED -- requirements
Module: bf16_add_sched

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port nreset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port req_valid_i, input, 2, per-requester operation request (bit k = requester k).
REQ-004 SHALL have port req_ready_o, output, 2, per-requester accept; one-hot or zero.
REQ-005 SHALL have port req0_a_i, input, 16, requester 0 operand A {sign[15], exp[14:7], man[6:0]}.
REQ-006 SHALL have port req0_b_i, input, 16, requester 0 operand B, same packing.
REQ-007 SHALL have port req1_a_i, input, 16, requester 1 operand A.
REQ-008 SHALL have port req1_b_i, input, 16, requester 1 operand B.
REQ-009 SHALL have port rsp_valid_o, output, 1, result register holds a valid result.
REQ-010 SHALL have port rsp_ready_i, input, 1, consumer accepts the result.
REQ-011 SHALL have port rsp_id_o, output, 1, requester index that issued the held result.
REQ-012 SHALL have port rsp_res_o, output, 16, BF16 sum A+B, same packing.
REQ-013 SHALL have port ops_cnt_o, output, 16, count of accepted operations.

Function
REQ-014 SHALL instantiate exactly one bf16_add, with sa/ea/ma and sb/eb/mb driven from the granted requester's operand fields.
REQ-015 Two-state FSM SHALL be used: EMPTY (no held result) and FULL (result held, rsp_valid_o=1).
REQ-016 Accept window SHALL be open when state is EMPTY, or when FULL with rsp_ready_i=1 in the same cycle.
REQ-017 In an open window, grant SHALL go to the valid requester holding priority; otherwise to the other one if valid; otherwise none.
REQ-018 req_ready_o[k] SHALL be 1 only for the granted requester; a transfer occurs when req_valid_i[k] & req_ready_o[k].
REQ-019 At most one operation SHALL be accepted per cycle.
REQ-020 Priority pointer SHALL reset to requester 0 and, after each transfer from requester k, move to requester 1-k; it SHALL be unchanged when no transfer occurs.
REQ-021 On a transfer, the next edge SHALL load rsp_res_o with the bf16_add output, rsp_id_o with k, and set the state to FULL. Latency is one cycle from accept to rsp_valid_o.
REQ-022 FULL with rsp_ready_i=1 and no new transfer SHALL go to EMPTY. FULL with rsp_ready_i=1 and a new transfer SHALL stay FULL with the new result, giving back-to-back throughput of 1 op/cycle.
REQ-023 While FULL and rsp_ready_i=0, rsp_res_o and rsp_id_o SHALL hold stable and req_ready_o SHALL be 2'b00.
REQ-024 rsp_res_o/rsp_id_o SHALL change only on a transfer edge, and SHALL keep their last values while EMPTY.
REQ-025 ops_cnt_o SHALL increment by 1 per transfer and wrap 16'hFFFF -> 16'h0000 without a flag.
REQ-026 req_ready_o SHALL depend combinationally on req_valid_i, state, pointer and rsp_ready_i only, never on the operand values.
REQ-027 Operand values SHALL be passed unchanged to bf16_add; rounding, special-value and signed-zero handling belong to bf16_add.

Reset
REQ-028 nreset low SHALL asynchronously force: state EMPTY, rsp_valid_o=0, rsp_id_o=0, rsp_res_o=16'h0000, ops_cnt_o=16'h0000, priority pointer=0.
REQ-029 While nreset is low, req_ready_o SHALL be 2'b00.
REQ-030 Reset asserted mid-operation SHALL discard any held or in-flight result; no result SHALL appear after release unless a new transfer occurs.
REQ-031 The first transfer SHALL be possible in the first rising edge after nreset deasserts.

Verification
REQ-032 Zero: req0 a=16'h0000, b=16'h8000, rsp_ready_i=1 -> next cycle rsp_valid_o=1, rsp_id_o=0, rsp_res_o=16'h0000, ops_cnt_o=1.
REQ-033 Arbitration: both valid after reset, req0 a=b=16'h3F80, req1 a=16'h4000 b=16'h3F80, rsp_ready_i=1 -> cycle N req_ready_o=2'b01, id 0 result 16'h4000; cycle N+1 req_ready_o=2'b10, id 1 result 16'h4040.
REQ-034 Backpressure: result 16'h4000 held, rsp_ready_i=0 for 3 cycles with req1 valid -> req_ready_o=2'b00 and rsp_res_o stable for 3 cycles; rsp_ready_i=1 -> req1 accepted in that same cycle.
REQ-035 Counter wrap: 65536 accepted operations -> ops_cnt_o returns to 16'h0000, with no gaps or stalls at continuous rsp_ready_i=1.
REQ-036 Reset mid-op: nreset pulsed low while FULL -> rsp_valid_o=0 immediately (asynchronous), ops_cnt_o=0, pointer back to requester 0 (both valid -> req0 granted first).
